// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the index/data widths, the architectural register count, the
// writeback entry carried through the per-requester buffers, and a helper
// that turns a register index into a scoreboard bit.
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 16;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    // One-hot scoreboard mask for a register index; register 0 never tracks.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] mask_s;
        if (idx == 4'd0) begin
            mask_s = 16'd0;
        end else begin
            mask_s = 16'd1 << idx;
        end
        return mask_s;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-requester writeback buffer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_entry    write one entry (caller guarantees not full)
//   pop                 drop the head entry (caller guarantees not empty)
//   full, empty, count  occupancy derived from the registered count
//   head                oldest entry
//   cmp_idx_a/b         register indices to look up in live entries
//   hit_a/b             some live entry targets cmp_idx_a/b
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  wb_entry_t            push_entry,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    output wb_entry_t            head,
    input  logic [REG_IDX_W-1:0] cmp_idx_a,
    input  logic [REG_IDX_W-1:0] cmp_idx_b,
    output logic                 hit_a,
    output logic                 hit_b
);

    wb_entry_t        entry_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointers (wrap by natural overflow) and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                entry_mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;
    assign head  = entry_mem_r[rd_ptr_r];

    // Search only the live window [rd_ptr, rd_ptr+count) for pending targets.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a = hit_a | ((CNT_W'(i) < count_r) &&
                             (entry_mem_r[rd_ptr_r + PTR_W'(i)].rd == cmp_idx_a));
            hit_b = hit_b | ((CNT_W'(i) < count_r) &&
                             (entry_mem_r[rd_ptr_r + PTR_W'(i)].rd == cmp_idx_b));
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Two writeback sources (req0 = ALU, req1 = load) each feed a small buffer;
// a round-robin arbiter drains one entry per cycle into a registered write
// port. A scoreboard of reserved destinations plus the buffered entries
// answers "does this source register still have a write in flight".
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   reqN_valid/ready/rd/data            writeback handshake per source
//   wen, write_Rd, write_data           registered register-file write port
//   rsv_valid, rsv_rd                   destination reservation from issue
//   read_Ra/Rb -> busy_Ra/Rb            source hazard lookup (combinational)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_REGS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_rd,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        wen,
    output logic [3:0]  write_Rd,
    output logic [31:0] write_data,
    input  logic        rsv_valid,
    input  logic [3:0]  rsv_rd,
    input  logic [3:0]  read_Ra,
    input  logic [3:0]  read_Rb,
    output logic        busy_Ra,
    output logic        busy_Rb
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                full0_s, full1_s, empty0_s, empty1_s;
    logic [CNT_W-1:0]    count0_s, count1_s;
    wb_entry_t           head0_s, head1_s, head_sel_s;
    logic                hit0_a_s, hit0_b_s, hit1_a_s, hit1_b_s;
    logic                push0_s, push1_s;
    logic                grant0_s, grant1_s, any_grant_s;
    logic                prefer1_r;
    logic                wen_r;
    logic [3:0]          write_rd_r;
    logic [31:0]         write_data_r;
    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] set_mask_s, clr_mask_s;

    // Ready is gated by rst_n so it reads 0 for the whole reset interval.
    assign req0_ready = rst_n & ~full0_s;
    assign req1_ready = rst_n & ~full1_s;
    assign push0_s    = req0_valid & req0_ready;
    assign push1_s    = req1_valid & req1_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push0_s),
        .push_entry ('{rd: req0_rd, data: req0_data}),
        .pop        (grant0_s),
        .full       (full0_s),
        .empty      (empty0_s),
        .count      (count0_s),
        .head       (head0_s),
        .cmp_idx_a  (read_Ra),
        .cmp_idx_b  (read_Rb),
        .hit_a      (hit0_a_s),
        .hit_b      (hit0_b_s)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push1_s),
        .push_entry ('{rd: req1_rd, data: req1_data}),
        .pop        (grant1_s),
        .full       (full1_s),
        .empty      (empty1_s),
        .count      (count1_s),
        .head       (head1_s),
        .cmp_idx_a  (read_Ra),
        .cmp_idx_b  (read_Rb),
        .hit_a      (hit1_a_s),
        .hit_b      (hit1_b_s)
    );

    // Round-robin grant: contention goes to the source not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!empty0_s && !empty1_s) begin
            grant0_s = ~prefer1_r;
            grant1_s = prefer1_r;
        end else if (!empty0_s) begin
            grant0_s = 1'b1;
        end else if (!empty1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign any_grant_s = grant0_s | grant1_s;
    assign head_sel_s  = grant1_s ? head1_s : head0_s;

    // Scoreboard edits: a new reservation wins over a same-bit clear.
    assign set_mask_s = rsv_valid ? idx_onehot(rsv_rd) : 16'd0;
    assign clr_mask_s = any_grant_s ? idx_onehot(head_sel_s.rd) : 16'd0;

    // Round-robin pointer: after serving req0, prefer req1 next, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer1_r <= 1'b0;
        end else if (any_grant_s) begin
            prefer1_r <= grant0_s;
        end else begin
            prefer1_r <= prefer1_r;
        end
    end

    // Write port register; rd=0 entries are consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_r        <= 1'b0;
            write_rd_r   <= 4'd0;
            write_data_r <= 32'd0;
        end else if (any_grant_s && (head_sel_s.rd != 4'd0)) begin
            wen_r        <= 1'b1;
            write_rd_r   <= head_sel_s.rd;
            write_data_r <= head_sel_s.data;
        end else begin
            wen_r        <= 1'b0;
            write_rd_r   <= write_rd_r;
            write_data_r <= write_data_r;
        end
    end

    // Pending-destination mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 16'd0;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    assign wen        = wen_r;
    assign write_Rd   = write_rd_r;
    assign write_data = write_data_r;

    assign busy_Ra = (read_Ra != 4'd0) && (pending_r[read_Ra] || hit0_a_s || hit1_a_s);
    assign busy_Rb = (read_Rb != 4'd0) && (pending_r[read_Rb] || hit0_b_s || hit1_b_s);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        wen;
    logic [3:0]  write_Rd;
    logic [31:0] write_data;
    logic        rsv_valid;
    logic [3:0]  rsv_rd, read_Ra, read_Rb;
    logic        busy_Ra, busy_Rb;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .NUM_REGS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .wen(wen), .write_Rd(write_Rd), .write_data(write_data),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .read_Ra(read_Ra), .read_Rb(read_Rb), .busy_Ra(busy_Ra), .busy_Rb(busy_Rb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        q0[$];
    ent_t        q1[$];
    bit   [15:0] pend;
    bit          last_was0;   // 1 when req0 was served most recently
    bit          m_wen;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    bit          acc0, acc1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_busy(input logic [3:0] idx);
        if (idx == 4'd0) return 1'b0;
        if (pend[idx]) return 1'b1;
        foreach (q0[i]) if (q0[i].rd == idx) return 1'b1;
        foreach (q1[i]) if (q1[i].rd == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        pend      = '0;
        last_was0 = 1'b0;
        m_wen     = 1'b0;
        m_rd      = 4'd0;
        m_data    = 32'd0;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsv_valid  = 1'b0;
    endtask

    // One clock: check combinational outputs, advance the model, check write port.
    task automatic cycle();
        bit   r0, r1;
        int   g;
        ent_t e;
        #1;
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        chk("ready0", req0_ready, r0);
        chk("ready1", req1_ready, r1);
        chk("busy_Ra", busy_Ra, exp_busy(read_Ra));
        chk("busy_Rb", busy_Rb, exp_busy(read_Rb));
        g = -1;
        if (q0.size() > 0 && q1.size() > 0) g = last_was0 ? 1 : 0;
        else if (q0.size() > 0) g = 0;
        else if (q1.size() > 0) g = 1;
        m_wen = 1'b0;
        if (g >= 0) begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            last_was0 = (g == 0);
            pend[e.rd] = 1'b0;
            if (e.rd != 4'd0) begin
                m_wen  = 1'b1;
                m_rd   = e.rd;
                m_data = e.data;
            end
        end
        if (rsv_valid && rsv_rd != 4'd0) pend[rsv_rd] = 1'b1;
        acc0 = req0_valid && r0;
        acc1 = req1_valid && r1;
        if (acc0) q0.push_back('{rd: req0_rd, data: req0_data});
        if (acc1) q1.push_back('{rd: req1_rd, data: req1_data});
        @(posedge clk);
        #1;
        chk("wen", wen, m_wen);
        chk("write_Rd", write_Rd, m_rd);
        chk("write_data", write_data, m_data);
    endtask

    // Hold reset for two edges, checking the reset state, then release.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_wen", wen, 1'b0);
        chk("rst_write_Rd", write_Rd, 4'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    initial begin
        int k1, guard;
        rst_n = 1'b0;
        req0_rd = 4'd0; req0_data = 32'd0; req1_rd = 4'd0; req1_data = 32'd0;
        rsv_rd = 4'd0; read_Ra = 4'd0; read_Rb = 4'd0;
        idle_inputs();
        model_clear();

        // Single transfer: write lands one edge after the push edge.
        do_reset();
        req0_valid = 1'b1; req0_rd = 4'd1; req0_data = 32'hA5A5A5A5;
        cycle();
        idle_inputs();
        cycle();
        chk("single_wen", wen, 1'b1);
        chk("single_rd", write_Rd, 4'd1);
        chk("single_data", write_data, 32'hA5A5A5A5);
        cycle();
        chk("single_wen_drop", wen, 1'b0);

        // Simultaneous pushes after reset: req0 first, then req1.
        do_reset();
        req0_valid = 1'b1; req0_rd = 4'd2; req0_data = 32'h11111111;
        req1_valid = 1'b1; req1_rd = 4'd3; req1_data = 32'h22222222;
        cycle();
        idle_inputs();
        cycle();
        chk("rr_first_rd", write_Rd, 4'd2);
        cycle();
        chk("rr_second_rd", write_Rd, 4'd3);
        cycle();

        // Both sources streaming; req1 holds valid until 4 entries accepted.
        do_reset();
        k1 = 0; guard = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        while (k1 < 4 && guard < 40) begin
            req0_rd = 4'(guard % 7 + 1); req0_data = 32'h0A000000 + 32'(guard);
            req1_rd = 4'(k1 + 8);        req1_data = 32'h1B000000 + 32'(k1);
            cycle();
            if (acc1) k1++;
            guard++;
        end
        chk("stream_accept_bound", 32'(k1), 32'd4);
        idle_inputs();
        repeat (6) cycle();

        // Reservation tracking through a load writeback.
        rsv_valid = 1'b1; rsv_rd = 4'd5; read_Ra = 4'd5; read_Rb = 4'd0;
        cycle();
        rsv_valid = 1'b0;
        #1 chk("rsv_busy", busy_Ra, 1'b1);
        req1_valid = 1'b1; req1_rd = 4'd5; req1_data = 32'h5A5A5A5A;
        cycle();
        req1_valid = 1'b0;
        cycle();
        chk("rsv_wen", wen, 1'b1);
        cycle();
        chk("rsv_busy_clear", busy_Ra, 1'b0);
        // Re-reserve on the same edge that pops the older write.
        req1_valid = 1'b1;
        cycle();
        req1_valid = 1'b0;
        rsv_valid = 1'b1; rsv_rd = 4'd5;
        cycle();
        rsv_valid = 1'b0;
        cycle();
        chk("rsv_same_edge_busy", busy_Ra, 1'b1);

        // rd=0 entry: consumed, never written, never busy.
        req0_valid = 1'b1; req0_rd = 4'd0; req0_data = 32'hFFFFFFFF; read_Ra = 4'd0;
        cycle();
        idle_inputs();
        cycle();
        chk("rd0_wen", wen, 1'b0);
        chk("rd0_busy", busy_Ra, 1'b0);
        cycle();

        // Fill both buffers, then reset mid-operation.
        req0_valid = 1'b1; req1_valid = 1'b1; rsv_valid = 1'b1; rsv_rd = 4'd9;
        req0_rd = 4'd7; req0_data = 32'h77777777;
        req1_rd = 4'd8; req1_data = 32'h88888888;
        repeat (3) cycle();
        @(posedge clk); #1;
        do_reset();
        read_Ra = 4'd7; read_Rb = 4'd9;
        repeat (3) cycle();
        chk("midrst_busy_a", busy_Ra, 1'b0);
        chk("midrst_busy_b", busy_Rb, 1'b0);
        chk("midrst_ready0", req0_ready, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_rd    = 4'($urandom_range(0, 7));
            req1_rd    = 4'($urandom_range(0, 7));
            req0_data  = $urandom;
            req1_data  = $urandom;
            rsv_valid  = ($urandom_range(0, 3) == 0);
            rsv_rd     = 4'($urandom_range(0, 7));
            read_Ra    = 4'($urandom_range(0, 7));
            read_Rb    = 4'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
